// File: rtl/status_display.sv
// N-digit seven-segment driver: top digit shows system status (lockup/error/heartbeat),
// lower digits show a captured hex value with leading-zero blanking, freeze and lockup blink.
module status_display #(
  parameter int unsigned DIGITS   = 6,
  parameter int unsigned HB_MSB   = 25,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [31:0]           value,
  input  logic                  value_valid,
  input  logic                  lockup,
  input  logic                  freeze,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  heartbeat
);

  localparam int VD = int'(DIGITS) - 1;
  localparam int VW = 4 * VD;

  localparam logic [6:0] PatL     = 7'h38;
  localparam logic [6:0] PatE     = 7'h79;
  localparam logic [6:0] PatO     = 7'h5C;
  localparam logic [6:0] PatBlank = 7'h00;

  logic [HB_MSB:0]     r_tick;
  logic                r_heartbeat;
  logic                r_lock_sticky;
  logic                r_valid;
  logic [VW-1:0]       r_disp;
  logic [7*DIGITS-1:0] r_seg;

  logic [7*DIGITS-1:0] w_seg_d;
  logic [3:0]          w_nib;
  logic                w_zero_run;
  logic                w_blink;
  logic                w_unused;

  assign w_unused = ^value[31:VW];

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      default: p = 7'h71;
    endcase
    return p;
  endfunction

  always_comb begin
    w_seg_d    = '1;
    w_nib      = 4'h0;
    w_zero_run = 1'b1;
    w_blink    = r_lock_sticky & r_tick[HB_MSB];
    // Walk value digits from the most significant down so the zero run tracks leading zeros.
    for (int i = 0; i < VD; i++) begin
      w_nib      = r_disp[4*(VD-1-i) +: 4];
      w_zero_run = w_zero_run & (w_nib == 4'h0);
      if (w_blink || (BLANK_LZ && w_zero_run && (i != VD - 1))) begin
        w_seg_d[7*(VD-1-i) +: 7] = ~PatBlank;
      end else begin
        w_seg_d[7*(VD-1-i) +: 7] = ~hex7(w_nib);
      end
    end
    if (r_lock_sticky) begin
      w_seg_d[7*VD +: 7] = ~PatL;
    end else if (!r_valid) begin
      w_seg_d[7*VD +: 7] = ~PatE;
    end else if (r_heartbeat) begin
      w_seg_d[7*VD +: 7] = ~PatO;
    end else begin
      w_seg_d[7*VD +: 7] = ~PatBlank;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_tick        <= '0;
      r_heartbeat   <= 1'b0;
      r_lock_sticky <= 1'b0;
      r_valid       <= 1'b0;
      r_disp        <= '0;
      r_seg         <= '1;
    end else begin
      r_tick      <= r_tick + {{HB_MSB{1'b0}}, 1'b1};
      r_heartbeat <= r_tick[HB_MSB] & r_tick[HB_MSB-2];
      if (lockup) begin
        r_lock_sticky <= 1'b1;
      end
      r_valid <= value_valid;
      if (value_valid && !freeze) begin
        r_disp <= value[VW-1:0];
      end
      r_seg <= w_seg_d;
    end
  end

  assign seg       = r_seg;
  assign heartbeat = r_heartbeat;

endmodule

// File: tb/tb_status_display.sv
// Scoreboard bench for status_display (DIGITS=6, HB_MSB=3): the driver queues expected
// segment/heartbeat values per edge; a negedge monitor compares and retires them.
module tb_status_display;

  logic        clk;
  logic        rst;
  logic [31:0] value;
  logic        value_valid;
  logic        lockup;
  logic        freeze;
  logic [41:0] seg;
  logic        heartbeat;

  int edge_n  = 0;
  int n_check = 0;
  int n_fail  = 0;

  typedef struct {
    int          e;
    bit          is_hb;
    logic [41:0] m;
    logic [41:0] v;
    string       nm;
  } chk_t;

  chk_t sb[$];

  status_display #(
    .DIGITS   (6),
    .HB_MSB   (3),
    .BLANK_LZ (1'b1)
  ) dut (
    .HCLK        (clk),
    .HRESET      (rst),
    .value       (value),
    .value_valid (value_valid),
    .lockup      (lockup),
    .freeze      (freeze),
    .seg         (seg),
    .heartbeat   (heartbeat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic logic [41:0] mk(input logic [6:0] d5, input logic [6:0] d4,
                                     input logic [6:0] d3, input logic [6:0] d2,
                                     input logic [6:0] d1, input logic [6:0] d0);
    return ~{d5, d4, d3, d2, d1, d0};
  endfunction

  task automatic exp_seg(input int e, input logic [41:0] m, input logic [41:0] v,
                         input string nm);
    chk_t c;
    c.e = e; c.is_hb = 1'b0; c.m = m; c.v = v; c.nm = nm;
    sb.push_back(c);
  endtask

  task automatic exp_hb(input int e, input logic v, input string nm);
    chk_t c;
    c.e = e; c.is_hb = 1'b1; c.m = '0; c.v = {41'h0, v}; c.nm = nm;
    sb.push_back(c);
  endtask

  task automatic wait_edge(input int e);
    while (edge_n < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: retire every expectation due at the edge just taken.
  always @(negedge clk) begin
    for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
      if (sb[i].e == edge_n) begin
        n_check++;
        if (sb[i].is_hb) begin
          if (heartbeat !== sb[i].v[0]) begin
            n_fail++;
            $display("FAIL %s edge %0d: heartbeat=%b expected %b",
                     sb[i].nm, edge_n, heartbeat, sb[i].v[0]);
          end
        end else if ((seg & sb[i].m) !== (sb[i].v & sb[i].m)) begin
          n_fail++;
          $display("FAIL %s edge %0d: seg=%h expected %h (mask %h)",
                   sb[i].nm, edge_n, seg, sb[i].v, sb[i].m);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: edge %0d, expected run to end by edge 42", edge_n);
    $fatal(1, "timeout");
  end

  initial begin
    logic [41:0] all_m;
    logic [41:0] val_m;
    logic [41:0] ones;
    logic [41:0] s_1a3f;
    logic [15:0] hb_pat;

    all_m  = '1;
    val_m  = {7'h00, {35{1'b1}}};
    ones   = '1;
    s_1a3f = mk(7'h00, 7'h00, 7'h06, 7'h77, 7'h4F, 7'h71);
    // heartbeat high after reset-relative edges 11,12,15,16 (bit index = edge-1 mod 16)
    hb_pat = 16'hCC00;

    rst         = 1'b1;
    value       = 32'h0001_2345;
    value_valid = 1'b1;
    lockup      = 1'b1;
    freeze      = 1'b0;

    exp_seg(1, all_m, ones, "reset_seg_e1");
    exp_seg(2, all_m, ones, "reset_seg_e2");
    exp_hb(1, 1'b0, "reset_hb_e1");
    exp_hb(2, 1'b0, "reset_hb_e2");
    for (int e = 3; e <= 34; e++) exp_hb(e, hb_pat[(e-3) % 16], "hb_phase");

    wait_edge(2);
    rst         = 1'b0;
    lockup      = 1'b0;
    value       = 32'h0000_1A3F;
    exp_seg(3, all_m, mk(7'h79, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F), "first_post_reset");
    exp_seg(4, all_m, s_1a3f, "decode_1a3f");
    exp_seg(5, all_m, s_1a3f, "pipe_hold_1a3f");

    wait_edge(4);
    value = 32'h0;
    exp_seg(6, all_m, mk(7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F), "zero_shows_0");

    wait_edge(6);
    value = 32'h0000_1A3F;
    exp_seg(8, all_m, s_1a3f, "redisplay_1a3f");

    wait_edge(8);
    value_valid = 1'b0;
    value       = 32'h000F_FFFF;
    exp_seg(9, all_m, s_1a3f, "invalid_latency");
    exp_seg(10, all_m, mk(7'h79, 7'h00, 7'h06, 7'h77, 7'h4F, 7'h71), "invalid_E_hold");

    wait_edge(10);
    value_valid = 1'b1;
    value       = 32'h0000_1A3F;
    exp_seg(11, all_m, mk(7'h79, 7'h00, 7'h06, 7'h77, 7'h4F, 7'h71), "E_clear_latency");
    exp_seg(12, all_m, s_1a3f, "E_cleared");

    wait_edge(12);
    value = 32'h0001_1111;
    wait_edge(13);
    freeze = 1'b1;
    value  = 32'h0002_2222;
    exp_seg(14, all_m, mk(7'h5C, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06), "freeze_hb_o_e14");
    exp_seg(15, all_m, mk(7'h5C, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06), "freeze_hb_o_e15");
    exp_seg(16, all_m, mk(7'h00, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06), "freeze_hold_e16");

    wait_edge(16);
    freeze = 1'b0;
    exp_seg(17, all_m, mk(7'h00, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06), "unfreeze_latency");
    exp_seg(18, all_m, mk(7'h5C, 7'h5B, 7'h5B, 7'h5B, 7'h5B, 7'h5B), "unfreeze_22222");
    exp_seg(19, all_m, mk(7'h5C, 7'h5B, 7'h5B, 7'h5B, 7'h5B, 7'h5B), "hb_o_e19");
    exp_seg(20, all_m, mk(7'h00, 7'h5B, 7'h5B, 7'h5B, 7'h5B, 7'h5B), "hb_off_e20");

    wait_edge(20);
    lockup = 1'b1;
    exp_seg(21, all_m, mk(7'h00, 7'h5B, 7'h5B, 7'h5B, 7'h5B, 7'h5B), "lock_latency");
    exp_seg(22, all_m, mk(7'h38, 7'h5B, 7'h5B, 7'h5B, 7'h5B, 7'h5B), "lock_L");

    wait_edge(21);
    lockup = 1'b0;
    exp_seg(26, all_m, mk(7'h38, 7'h5B, 7'h5B, 7'h5B, 7'h5B, 7'h5B), "lock_sticky_shown");
    exp_seg(27, all_m, mk(7'h38, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00), "lock_blink_start");
    exp_seg(30, all_m, mk(7'h38, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00), "lock_L_over_o");
    exp_seg(34, all_m, mk(7'h38, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00), "lock_blink_end");
    exp_seg(35, all_m, mk(7'h38, 7'h5B, 7'h5B, 7'h5B, 7'h5B, 7'h5B), "lock_unblink");

    wait_edge(35);
    lockup      = 1'b1;
    value_valid = 1'b0;
    value       = 32'h0003_3333;
    exp_seg(37, all_m, mk(7'h38, 7'h5B, 7'h5B, 7'h5B, 7'h5B, 7'h5B), "L_over_E_hold");
    exp_seg(37, val_m, mk(7'h00, 7'h5B, 7'h5B, 7'h5B, 7'h5B, 7'h5B), "invalid_not_captured");

    wait_edge(36);
    lockup = 1'b0;

    wait_edge(37);
    rst         = 1'b1;
    value_valid = 1'b1;
    value       = 32'h0000_0005;
    exp_seg(38, all_m, ones, "midrun_reset_seg");
    exp_hb(38, 1'b0, "midrun_reset_hb");

    wait_edge(38);
    rst = 1'b0;
    exp_seg(39, all_m, mk(7'h79, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F), "reset_clears_L");
    exp_seg(40, all_m, mk(7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h6D), "post_reset_value");

    wait_edge(42);
    while (sb.size() > 0) begin
      n_check++;
      n_fail++;
      $display("FAIL %s: expectation for edge %0d never checked, now edge %0d",
               sb[0].nm, sb[0].e, edge_n);
      void'(sb.pop_front());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule

// File: doc/status_display.md
# status_display

Parametrised status and value display driver for the FPGA board wrapper. It generalises the single status digit into an N-digit seven-segment bank. The top digit shows system status: lockup, invalid data, heartbeat or blank. The lower digits show a captured hex value, with optional leading-zero blanking, freeze/hold and a sticky lockup indication. It sits between the `soc` outputs (`oPort`, `LOCKUP`) and the board HEX pins.

## Interface
- `DIGITS`, default 6: total digits, range 2..8. Digit `DIGITS-1` is the status digit; digits `DIGITS-2..0` show the value.
- `HB_MSB`, default 25: MSB index of the heartbeat tick counter, minimum 3.
- `BLANK_LZ`, default 1: when 1, leading zero value digits are blanked.
- `HCLK` input 1: sole clock, rising edge.
- `HRESET` input 1: reset, synchronous, active-high.
- `value` input 32: value to display; only the low `4*(DIGITS-1)` bits are used.
- `value_valid` input 1: 1 means `value` is valid data; 0 means the error state.
- `lockup` input 1: processor lockup indication.
- `freeze` input 1: 1 holds the captured value.
- `seg` output `7*DIGITS`: active-low segments. Digit d occupies `seg[7d+6:7d]`, bit order gfedcba.
- `heartbeat` output 1: registered heartbeat.

## Operation
- **Reset values** (`HRESET`=1 at a rising edge): `tick`=0, `heartbeat`=0, `lock_sticky`=0, `valid_r`=0, `disp`=0, `seg`=all ones (blank).
- **tick**: `HB_MSB+1`-bit counter, +1 every cycle, wraps to 0 with no flag.
- **heartbeat**: `heartbeat <= tick[HB_MSB] & tick[HB_MSB-2]`, using the pre-increment value of `tick`.
- **lock_sticky**: set on any cycle with `lockup`=1. Cleared only by `HRESET`; `HRESET` has priority if both are asserted.
- **valid_r**: `valid_r <= value_valid` every cycle, independent of `freeze`.
- **disp**: `disp <= value` when `value_valid`=1 and `freeze`=0; otherwise holds. An invalid value is never captured.
- **Status digit**, decoded from registered state in priority order:
  - `lock_sticky` → L
  - `!valid_r` → E
  - `heartbeat` → o
  - otherwise blank
- **Value digit** d: hex decode of nibble `disp[4d+3:4d]`.
  - With `BLANK_LZ`=1, digit d>0 is blank when it and every higher value nibble are 0. Digit 0 is always shown, so a value of 0 shows "0".
  - When `lock_sticky`=1, all value digits are blanked while `tick[HB_MSB]`=1 (blink). The status digit does not blink.
- **Segment patterns**, active-high gfedcba hex, output inverted:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - L=38, E(status)=79, o=5C, blank=00
- All of `seg` is registered: one register stage after `disp`, `valid_r`, `heartbeat`, `lock_sticky` and `tick`.

## Timing
- **value → seg**: 2 edges. Edge 1 captures `disp`; edge 2 updates `seg`.
- **value_valid → status**: 2 edges (via `valid_r`).
- **lockup → L**: 2 edges (via `lock_sticky`). A single-cycle pulse is sufficient.
- **tick → status o**: 2 edges (via `heartbeat`).
- **Heartbeat period**: `2^(HB_MSB+1)` cycles, high for 1/4 of the period.
- **Reset mid-operation**: the next edge forces all reset values, including a blank `seg`. After `HRESET` drops, the first valid `seg` appears 2 edges later.
- **Simultaneous events**:
  - `freeze` with `value_valid`=1: hold wins.
  - `lockup` with `value_valid`=0: L wins on the status digit, while `disp` still holds.

## Test plan
- **Reset**: hold `HRESET` for 2 edges with arbitrary inputs → `seg`=all ones and `heartbeat`=0 on every edge; release → first non-reset `seg` appears at edge 2.
- **Value decode and blanking**: DIGITS=6, BLANK_LZ=1, `value`=0x0001A3F, valid=1, `lockup`=0, from reset.
  - After 2 edges, digits 4..0 show patterns ~{00,06,77,4F,71}, i.e. blank 1 A 3 F.
  - Then `value`=0 → digits 4..1 blank and digit 0=~3F.
- **Invalid data**: after the 0x1A3F display, drive valid=0 and `value`=0xFFFFF → status=~79 (E) 2 edges later and value digits unchanged; restore valid → E clears 2 edges later.
- **Sticky lockup**: 1-cycle `lockup` pulse.
  - Status=~38 (L) from edge 2 and remains after `lockup`=0.
  - Value digits blank whenever `tick[HB_MSB]`=1.
  - Asserting `HRESET` clears L.
- **Freeze**: `freeze`=1 with valid `value` stepping 0x11111→0x22222 → display stays 0x11111; `freeze`=0 → 0x22222 appears 2 edges later.
- **Heartbeat**: HB_MSB=3, from reset release.
  - `heartbeat` is high after edges 11,12,15,16 and low otherwise; the pattern repeats every 16 edges.
  - Status digit=~5C (o) one edge after each high `heartbeat`.
